// File: rtl/opdma_pkg.sv
// Shared definitions for the operand DMA sequencer: register map, CTRL/STATUS
// bit positions, FSM states and the master-port request payload.
package opdma_pkg;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned IDX_W = 3;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_SRC    = 4'h4;
    localparam logic [3:0] REG_DST    = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_CLEAR   = 1;
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_IDX_LSB = 4;

    localparam logic [AW-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_OP,
        ST_WR_OP,
        ST_RD_LO,
        ST_RD_HI,
        ST_WR_LO,
        ST_WR_HI,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } bus_req_t;

    // Byte-lane merge of a slave write into an existing register value.
    function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] wd,
                                                 input logic [SW-1:0] strb);
        strb_merge = old;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) strb_merge[b*8 +: 8] = wd[b*8 +: 8];
        end
    endfunction

endpackage

// File: rtl/opdma_regs.sv
// Slave-side register window of the operand DMA: address decode, SRC/DST
// registers, STATUS readback and CTRL start/clear pulses to the sequencer.
module opdma_regs
    import opdma_pkg::*;
#(
    parameter logic [AW-1:0] ADDR_BASE = 32'h0100_5000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [AW-1:0]    s_addr,
    input  logic [DW-1:0]    s_wdata,
    input  logic [SW-1:0]    s_wstrb,
    output logic [DW-1:0]    s_rdata,
    input  logic             busy,
    input  logic             done,
    input  logic [IDX_W-1:0] idx,
    output logic [AW-1:0]    src,
    output logic [AW-1:0]    dst,
    output logic             start_c,
    output logic             clear_c
);

    logic          in_win_c;
    logic          acc_c;
    logic          wr_c;
    logic [3:0]    off_c;
    logic [DW-1:0] rd_mux_c;

    assign off_c    = s_addr[3:0];
    assign in_win_c = (s_addr[AW-1:4] == ADDR_BASE[AW-1:4]);
    // One access per request: fires on the edge that raises s_ready.
    assign acc_c    = s_valid && in_win_c && !s_ready;
    assign wr_c     = acc_c && (s_wstrb != '0);
    assign start_c  = wr_c && (off_c == REG_CTRL) && s_wstrb[0] && s_wdata[CTRL_START];
    assign clear_c  = wr_c && (off_c == REG_CTRL) && s_wstrb[0] && s_wdata[CTRL_CLEAR];

    always_comb begin
        rd_mux_c = '0;
        case (off_c)
            REG_SRC:    rd_mux_c = src;
            REG_DST:    rd_mux_c = dst;
            REG_STATUS: begin
                rd_mux_c[STAT_BUSY]               = busy;
                rd_mux_c[STAT_DONE]               = done;
                rd_mux_c[STAT_IDX_LSB +: IDX_W]   = idx;
            end
            default:    rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_ready <= 1'b0;
            s_rdata <= '0;
            src     <= '0;
            dst     <= '0;
        end else begin
            s_ready <= s_valid && in_win_c;
            if (acc_c) s_rdata <= wr_c ? '0 : rd_mux_c;
            // Address registers are frozen while a transfer is running.
            if (wr_c && !busy) begin
                if (off_c == REG_SRC) src <= strb_merge(src, s_wdata, s_wstrb) & WORD_MASK;
                if (off_c == REG_DST) dst <= strb_merge(dst, s_wdata, s_wstrb) & WORD_MASK;
            end
        end
    end

endmodule

// File: rtl/operand_dma.sv
// Operand DMA: fetches N operands, feeds the product accelerator and stores
// the 64-bit result. Optional irq output under `define OPDMA_IRQ_EN.
module operand_dma
    import opdma_pkg::*;
#(
    parameter logic [AW-1:0] ADDR_BASE = 32'h0100_5000,
    parameter logic [AW-1:0] ACC_WRITE = 32'h0100_3000,
    parameter logic [AW-1:0] ACC_READ  = 32'h0100_4000,
    parameter int unsigned   N         = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_wdata,
    input  logic [SW-1:0] s_wstrb,
    output logic [DW-1:0] s_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [SW-1:0] m_wstrb,
    input  logic [DW-1:0] m_rdata
`ifdef OPDMA_IRQ_EN
    ,
    output logic          irq
`endif
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t           state, state_d, after_gap, after_gap_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [DW-1:0]    op, op_d, res_lo, res_lo_d, res_hi, res_hi_d;
    logic             done, done_d;
    logic             m_valid_d;
    bus_req_t         req, req_d;
    logic [AW-1:0]    src, dst;
    logic             busy_c, start_c, clear_c, xfer_c;

    assign busy_c  = (state != ST_IDLE);
    assign xfer_c  = m_valid && m_ready;
    assign m_addr  = req.addr;
    assign m_wdata = req.wdata;
    assign m_wstrb = req.wstrb;

    opdma_regs #(.ADDR_BASE(ADDR_BASE)) u_regs (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .busy    (busy_c),
        .done    (done),
        .idx     (idx),
        .src     (src),
        .dst     (dst),
        .start_c (start_c),
        .clear_c (clear_c)
    );

    // Master request issued on entry to a bus state.
    function automatic bus_req_t build_req(input state_t st, input logic [IDX_W-1:0] i,
                                           input logic [AW-1:0] s, input logic [AW-1:0] d,
                                           input logic [DW-1:0] o, input logic [DW-1:0] lo,
                                           input logic [DW-1:0] hi);
        logic [AW-1:0] off;
        off       = AW'({i, 2'b00});
        build_req = '0;
        case (st)
            ST_RD_OP: build_req.addr = s + off;
            ST_WR_OP: begin
                build_req.addr  = ACC_WRITE + off;
                build_req.wdata = o;
                build_req.wstrb = '1;
            end
            ST_RD_LO: build_req.addr = ACC_READ;
            ST_RD_HI: build_req.addr = ACC_READ + AW'(4);
            ST_WR_LO: begin
                build_req.addr  = d;
                build_req.wdata = lo;
                build_req.wstrb = '1;
            end
            ST_WR_HI: begin
                build_req.addr  = d + AW'(4);
                build_req.wdata = hi;
                build_req.wstrb = '1;
            end
            default:  build_req = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            after_gap <= ST_IDLE;
            idx       <= '0;
            op        <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            done      <= 1'b0;
            m_valid   <= 1'b0;
            req       <= '0;
        end else begin
            state     <= state_d;
            after_gap <= after_gap_d;
            idx       <= idx_d;
            op        <= op_d;
            res_lo    <= res_lo_d;
            res_hi    <= res_hi_d;
            done      <= done_d;
            m_valid   <= m_valid_d;
            req       <= req_d;
        end
    end

    always_comb begin
        state_d     = state;
        after_gap_d = after_gap;
        idx_d       = idx;
        op_d        = op;
        res_lo_d    = res_lo;
        res_hi_d    = res_hi;
        done_d      = done;
        m_valid_d   = m_valid;
        req_d       = req;
        if (clear_c) done_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_c) begin
                    done_d    = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_RD_OP;
                    m_valid_d = 1'b1;
                    req_d     = build_req(ST_RD_OP, '0, src, dst, op, res_lo, res_hi);
                end
            end
            ST_GAP: begin
                if (after_gap == ST_IDLE) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d   = after_gap;
                    m_valid_d = 1'b1;
                    req_d     = build_req(after_gap, idx, src, dst, op, res_lo, res_hi);
                end
            end
            default: begin
                // Bus state: hold the request until accepted, then drop valid for a gap.
                if (xfer_c) begin
                    state_d   = ST_GAP;
                    m_valid_d = 1'b0;
                    case (state)
                        ST_RD_OP: begin
                            op_d        = m_rdata;
                            after_gap_d = ST_WR_OP;
                        end
                        ST_WR_OP: begin
                            if (idx == IDX_LAST) begin
                                after_gap_d = ST_RD_LO;
                            end else begin
                                idx_d       = IDX_W'(idx + 1'b1);
                                after_gap_d = ST_RD_OP;
                            end
                        end
                        ST_RD_LO: begin
                            res_lo_d    = m_rdata;
                            after_gap_d = ST_RD_HI;
                        end
                        ST_RD_HI: begin
                            res_hi_d    = m_rdata;
                            after_gap_d = ST_WR_LO;
                        end
                        ST_WR_LO: after_gap_d = ST_WR_HI;
                        default:  after_gap_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

`ifdef OPDMA_IRQ_EN
    // irq mirrors the done flag edge-for-edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) irq <= 1'b0;
        else         irq <= done_d;
    end
`endif

endmodule
